// File: rtl/i4_pkg.sv
// i4_pkg: shared widths, mode IDs and FSM encoding for the 4x4 intra mode-decision stage
package i4_pkg;
    localparam int BIT_WIDTH  = 8;
    localparam int BLOCK_SIZE = 4;
    localparam int MODE_WIDTH = 4;
    localparam int SAD_WIDTH  = BIT_WIDTH + 4;
    localparam int NPIX       = BLOCK_SIZE * BLOCK_SIZE;
    localparam int RES_WIDTH  = BIT_WIDTH + 1;

    localparam logic [MODE_WIDTH-1:0] MODE_DC = 4'd0;
    localparam logic [MODE_WIDTH-1:0] MODE_TM = 4'd1;
    localparam logic [MODE_WIDTH-1:0] MODE_VE = 4'd2;
    localparam logic [MODE_WIDTH-1:0] MODE_HE = 4'd3;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    function automatic logic [BIT_WIDTH-1:0] absdiff(input logic [BIT_WIDTH-1:0] a, input logic [BIT_WIDTH-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction
endpackage

// File: rtl/sad16_tree.sv
// sad16_tree: 4-level unsigned adder tree summing 16 absolute differences into a SAD
module sad16_tree
    import i4_pkg::*;
(
    input  logic [NPIX*BIT_WIDTH-1:0] ad,
    output logic [SAD_WIDTH-1:0]      sad
);
    logic [SAD_WIDTH-1:0] l0 [16];
    logic [SAD_WIDTH-1:0] l1 [8];
    logic [SAD_WIDTH-1:0] l2 [4];
    logic [SAD_WIDTH-1:0] l3 [2];

    for (genvar g = 0; g < 16; g++) begin : g_l0
        assign l0[g] = {{(SAD_WIDTH-BIT_WIDTH){1'b0}}, ad[g*BIT_WIDTH +: BIT_WIDTH]};
    end
    for (genvar g = 0; g < 8; g++) begin : g_l1
        assign l1[g] = l0[2*g] + l0[2*g+1];
    end
    for (genvar g = 0; g < 4; g++) begin : g_l2
        assign l2[g] = l1[2*g] + l1[2*g+1];
    end
    for (genvar g = 0; g < 2; g++) begin : g_l3
        assign l3[g] = l2[2*g] + l2[2*g+1];
    end
    assign sad = l3[0] + l3[1];
endmodule

// File: rtl/i4_mode_select.sv
// i4_mode_select: picks the minimum-SAD 4x4 intra candidate per group; I4_MODE_SELECT_RESIDUAL_OUT_EN adds the residual output
module i4_mode_select
    import i4_pkg::*;
(
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      cand_valid,
    output logic                      cand_ready,
    input  logic                      cand_first,
    input  logic                      cand_last,
    input  logic [MODE_WIDTH-1:0]     cand_mode,
    input  logic [NPIX*BIT_WIDTH-1:0] cand_pred,
    input  logic [NPIX*BIT_WIDTH-1:0] src,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MODE_WIDTH-1:0]     best_mode,
    output logic [SAD_WIDTH-1:0]      best_sad,
    output logic [NPIX*BIT_WIDTH-1:0] best_pred,
    output logic [NPIX*RES_WIDTH-1:0] best_res,
    output logic                      seq_err
);
    state_t                    state;
    logic                      ready_en;
    logic                      s1_valid;
    logic                      s1_first;
    logic                      s1_last;
    logic [MODE_WIDTH-1:0]     s1_mode;
    logic [NPIX*BIT_WIDTH-1:0] s1_pred;
    logic [NPIX*BIT_WIDTH-1:0] s1_ad;
    logic [NPIX*BIT_WIDTH-1:0] src_q;
    logic [NPIX*BIT_WIDTH-1:0] src_cur;
    logic [NPIX*BIT_WIDTH-1:0] ad_next;
    logic [SAD_WIDTH-1:0]      s1_sad;
    logic                      accept;
    logic                      take;

    // ready_en holds the input closed while in reset and until the first clock after release
    assign cand_ready = ready_en & ~out_valid & ~(s1_valid & s1_last);
    assign accept     = cand_valid & cand_ready;
    // a candidate counts only if it opens a group or continues an open one
    assign take       = s1_valid & (s1_first | (state == ACC));

    // the first candidate compares against the live source, later ones against the captured copy
    always_comb begin
        src_cur = cand_first ? src : src_q;
        ad_next = '0;
        for (int p = 0; p < NPIX; p++)
            ad_next[p*BIT_WIDTH +: BIT_WIDTH] = absdiff(src_cur[p*BIT_WIDTH +: BIT_WIDTH], cand_pred[p*BIT_WIDTH +: BIT_WIDTH]);
    end

    sad16_tree u_sad (
        .ad  (s1_ad),
        .sad (s1_sad)
    );

`ifdef I4_MODE_SELECT_RESIDUAL_OUT_EN
    logic [NPIX*RES_WIDTH-1:0] res_next;

    // 9-bit two's complement src minus pred for the S2 candidate
    always_comb begin
        res_next = '0;
        for (int p = 0; p < NPIX; p++)
            res_next[p*RES_WIDTH +: RES_WIDTH] = {1'b0, src_q[p*BIT_WIDTH +: BIT_WIDTH]} - {1'b0, s1_pred[p*BIT_WIDTH +: BIT_WIDTH]};
    end
`else
    assign best_res = '0;
`endif

    // S1: register absolute differences and candidate tags on accept, capture the group source
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_en <= 1'b0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= '0;
            s1_pred  <= '0;
            s1_ad    <= '0;
            src_q    <= '0;
        end else begin
            ready_en <= 1'b1;
            s1_valid <= accept;
            if (accept) begin
                s1_first <= cand_first;
                s1_last  <= cand_last;
                s1_mode  <= cand_mode;
                s1_pred  <= cand_pred;
                s1_ad    <= ad_next;
                if (cand_first)
                    src_q <= src;
            end
        end
    end

    // S2 and FSM: keep the strict minimum of the group, flag protocol errors, hold the result until taken
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            best_mode <= '0;
            best_sad  <= '1;
            best_pred <= '0;
            seq_err   <= 1'b0;
`ifdef I4_MODE_SELECT_RESIDUAL_OUT_EN
            best_res  <= '0;
`endif
        end else begin
            if (s1_valid & (s1_first ? (state == ACC) : (state != ACC)))
                seq_err <= 1'b1;
            if (take & (s1_first | (s1_sad < best_sad))) begin
                best_mode <= s1_mode;
                best_sad  <= s1_sad;
                best_pred <= s1_pred;
`ifdef I4_MODE_SELECT_RESIDUAL_OUT_EN
                best_res  <= res_next;
`endif
            end
            if (take) begin
                state     <= s1_last ? DONE : ACC;
                out_valid <= s1_last;
            end else if (out_valid & out_ready) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end
        end
    end
endmodule
